// File: rtl/conway_pkg.sv
// Shared types and constants for the Conway row pipeline.
// Holds the controller state enum, the life rule constants and the
// neighbour-count width used by the per-cell rule evaluators.
package conway_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Eight neighbours need four bits to count.
    localparam int NCOUNT_W = 4;

    localparam logic [NCOUNT_W-1:0] BIRTH_N   = 4'd3;
    localparam logic [NCOUNT_W-1:0] SURVIVE_N = 4'd2;

    // Number of live cells in a three-cell column slice.
    function automatic logic [NCOUNT_W-1:0] count3(input logic [2:0] v);
        return NCOUNT_W'(v[0]) + NCOUNT_W'(v[1]) + NCOUNT_W'(v[2]);
    endfunction

    // Life rule: birth on exactly BIRTH_N, survival on SURVIVE_N as well.
    function automatic logic rule_next(input logic alive, input logic [NCOUNT_W-1:0] n_live);
        return (n_live == BIRTH_N) || (alive && (n_live == SURVIVE_N));
    endfunction

endpackage

// File: rtl/conway_cell_array.sv
// WIDTH parallel combinational rule evaluators producing one next-generation
// row from the rows above, current and below.
// Build option: CONWAY_WRAP_EN makes columns wrap (column -1 is WIDTH-1,
// column WIDTH is 0); otherwise cells beyond the row edges are dead.
module conway_cell_array
    import conway_pkg::*;
#(
    parameter int WIDTH = 20
)
(
    input  logic [WIDTH-1:0] above,
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] below,
    output logic [WIDTH-1:0] next_row
);

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            logic [2:0]          left_col;
            logic [2:0]          right_col;
            logic [NCOUNT_W-1:0] n_live;

            if (i == 0) begin : g_left_edge
`ifdef CONWAY_WRAP_EN
                assign left_col = {above[WIDTH-1], cur[WIDTH-1], below[WIDTH-1]};
`else
                assign left_col = 3'b000;
`endif
            end else begin : g_left
                assign left_col = {above[i-1], cur[i-1], below[i-1]};
            end

            if (i == WIDTH-1) begin : g_right_edge
`ifdef CONWAY_WRAP_EN
                assign right_col = {above[0], cur[0], below[0]};
`else
                assign right_col = 3'b000;
`endif
            end else begin : g_right
                assign right_col = {above[i+1], cur[i+1], below[i+1]};
            end

            // The cell itself is excluded: only above/below from its own column.
            assign n_live = count3(left_col) + count3(right_col)
                          + NCOUNT_W'(above[i]) + NCOUNT_W'(below[i]);

            assign next_row[i] = rule_next(cur[i], n_live);
        end
    endgenerate

endmodule

// File: rtl/conway_row_pipeline.sv
// Streaming Game-of-Life engine: takes one frame row per handshake and emits
// the next generation of the previous row, with a final flush beat for the
// last row (below-neighbour row dead).
// Build option: CONWAY_WRAP_EN (wrap columns, see conway_cell_array).
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for row 0 of a frame; above row is dead
//   ST_RUN   | rows 1..ROWS-1 accepted; each accept emits the row before it
//   ST_FLUSH | all rows in; emit the last row with a dead row below it
module conway_row_pipeline
    import conway_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int ROWS  = 16,
    parameter int GEN_W = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_row,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_row,
    output logic             out_last,
    output logic [GEN_W-1:0] gen_count
);

    localparam int              CNT_W    = $clog2(ROWS + 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    state_t             state;
    state_t             state_nx;
    logic [WIDTH-1:0]   above;
    logic [WIDTH-1:0]   cur;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   below_sel;
    logic [WIDTH-1:0]   next_row;
    logic               in_ready_fsm;
    logic               load_flush;
    logic               accept;
    logic               out_fire;
    logic               load_out;

    // Rule evaluation: in FLUSH the row below the last row is dead.
    assign below_sel = (state == ST_FLUSH) ? '0 : in_row;

    conway_cell_array #(
        .WIDTH (WIDTH)
    ) u_cells (
        .above    (above),
        .cur      (cur),
        .below    (below_sel),
        .next_row (next_row)
    );

    // Next-state and handshake decode.
    always_comb begin
        state_nx     = state;
        in_ready_fsm = 1'b0;
        load_flush   = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready_fsm = 1'b1;
                if (in_valid) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                in_ready_fsm = !out_valid || out_ready;
                if (in_valid && in_ready_fsm && (count == LAST_ROW)) begin
                    state_nx = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!out_valid || out_ready) begin
                    load_flush = 1'b1;
                    state_nx   = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Reset gates in_ready so nothing can look accepted while held in reset.
    assign in_ready = rst_n && in_ready_fsm;
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign load_out = ((state == ST_RUN) && accept) || load_flush;

    // State register; clear aborts the frame from any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Row window (above/cur) and row counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            above <= '0;
            cur   <= '0;
            count <= '0;
        end else if (clear) begin
            above <= '0;
            cur   <= '0;
            count <= '0;
        end else if ((state == ST_IDLE) && accept) begin
            above <= '0;
            cur   <= in_row;
            count <= CNT_W'(1);
        end else if ((state == ST_RUN) && accept) begin
            above <= cur;
            cur   <= in_row;
            count <= count + CNT_W'(1);
        end else if (load_flush) begin
            above <= '0;
            cur   <= '0;
            count <= '0;
        end
    end

    // One-entry output register; a load and a drain in the same cycle keep
    // out_valid high so full-rate streaming has no bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_row   <= '0;
            out_last  <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (load_out) begin
            out_valid <= 1'b1;
            out_row   <= next_row;
            out_last  <= load_flush;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    // Completed-frame counter; a handshake voided by clear does not count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_count <= '0;
        end else if (!clear && out_fire && out_last) begin
            gen_count <= gen_count + GEN_W'(1);
        end
    end

endmodule

// File: tb/tb_conway_row_pipeline.sv
// Directed bench for conway_row_pipeline (WIDTH=8, ROWS=4) with an
// output scoreboard. Works with or without CONWAY_WRAP_EN defined.
module tb_conway_row_pipeline;

    localparam int WIDTH = 8;
    localparam int ROWS  = 4;
    localparam int GEN_W = 16;

    typedef logic [ROWS-1:0][WIDTH-1:0] frame_t;
    typedef struct packed {
        logic [WIDTH-1:0] row;
        logic             last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_row = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_row;
    logic             out_last;
    logic [GEN_W-1:0] gen_count;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   beats  = 0;

    conway_row_pipeline #(
        .WIDTH (WIDTH),
        .ROWS  (ROWS),
        .GEN_W (GEN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_last  (out_last),
        .gen_count (gen_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference life step for one row, written cell by cell.
    function automatic logic [WIDTH-1:0] next_model(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] c,
                                                    input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] res;
        int n;
        int j;
        res = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = 0;
            for (int d = -1; d <= 1; d++) begin
                j = i + d;
`ifdef CONWAY_WRAP_EN
                j = (j + WIDTH) % WIDTH;
`endif
                if (j >= 0 && j < WIDTH) begin
                    n += int'(a[j]) + int'(b[j]);
                    if (d != 0) n += int'(c[j]);
                end
            end
            res[i] = (n == 3) || (c[i] && n == 2);
        end
        return res;
    endfunction

    task automatic push_exp(input logic [WIDTH-1:0] r, input logic l);
        sb.push_back('{row: r, last: l});
    endtask

    task automatic push_model_frame(input frame_t f);
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        for (int r = 0; r < ROWS; r++) begin
            a = (r == 0) ? '0 : f[r-1];
            b = (r == ROWS-1) ? '0 : f[r+1];
            sb.push_back('{row: next_model(a, f[r], b), last: (r == ROWS-1)});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one row and wait (bounded) for its accept; in_valid stays high.
    task automatic push_row(input logic [WIDTH-1:0] r);
        logic ok;
        int   t;
        ok = 1'b0;
        t  = 0;
        in_valid = 1'b1;
        in_row   = r;
        do begin
            @(negedge clk);
            ok = in_ready;
            tick();
            t++;
        end while (!ok && t < 50);
        chk("in_accept", {31'b0, ok}, 32'd1);
    endtask

    task automatic send_frame(input frame_t f);
        for (int r = 0; r < ROWS; r++) push_row(f[r]);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() > 0 && t < 60) begin
            tick();
            t++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        tick();
    endtask

    function automatic frame_t rand_frame();
        frame_t f;
        for (int r = 0; r < ROWS; r++) f[r] = WIDTH'($urandom);
        return f;
    endfunction

    // Output monitor: every output handshake pops and checks the scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            beats++;
            chk("sb_underflow", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_row", 32'(out_row), 32'(e.row));
                chk("out_last", 32'(out_last), 32'(e.last));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        frame_t blinker;
        frame_t wrapf;
        frame_t fr;
        blinker = '0;
        blinker[1] = 8'h1C;
        wrapf = '0;
        wrapf[1] = 8'h83;

        // Reset state
        tick();
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_row", 32'(out_row), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_gen", 32'(gen_count), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Blinker frame
        push_exp(8'h08, 1'b0); push_exp(8'h08, 1'b0);
        push_exp(8'h08, 1'b0); push_exp(8'h00, 1'b1);
        out_ready = 1'b1;
        send_frame(blinker);
        in_valid = 1'b0;
        drain();
        chk("gen_after_f1", 32'(gen_count), 32'd1);

        // Back-pressure: stall 5 cycles after the first out_valid
        push_exp(8'h08, 1'b0); push_exp(8'h08, 1'b0);
        push_exp(8'h08, 1'b0); push_exp(8'h00, 1'b1);
        push_row(8'h00);
        push_row(8'h1C);
        out_ready = 1'b0;
        in_row    = 8'h00;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_row", 32'(out_row), 32'h08);
            tick();
        end
        out_ready = 1'b1;
        push_row(8'h00);
        push_row(8'h00);
        in_valid = 1'b0;
        drain();
        chk("gen_after_stall", 32'(gen_count), 32'd2);

        // Column-edge behaviour
`ifdef CONWAY_WRAP_EN
        push_exp(8'h01, 1'b0); push_exp(8'h01, 1'b0);
        push_exp(8'h01, 1'b0); push_exp(8'h00, 1'b1);
`else
        push_exp(8'h00, 1'b0); push_exp(8'h00, 1'b0);
        push_exp(8'h00, 1'b0); push_exp(8'h00, 1'b1);
`endif
        send_frame(wrapf);
        in_valid = 1'b0;
        drain();
        chk("gen_after_wrap", 32'(gen_count), 32'd3);

        // Two back-to-back frames at full rate
        fr = rand_frame();
        push_exp(8'h08, 1'b0); push_exp(8'h08, 1'b0);
        push_exp(8'h08, 1'b0); push_exp(8'h00, 1'b1);
        push_model_frame(fr);
        beats = 0;
        send_frame(blinker);
        send_frame(fr);
        in_valid = 1'b0;
        drain();
        chk("b2b_beats", 32'(beats), 32'd8);
        chk("gen_after_b2b", 32'(gen_count), 32'd5);

        // Clear after two rows
        out_ready = 1'b0;
        push_row(WIDTH'($urandom));
        push_row(WIDTH'($urandom));
        in_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        chk("pre_clear_valid", 32'(out_valid), 32'd1);
        tick();
        clear = 1'b0;
        @(negedge clk);
        chk("clear_out_valid", 32'(out_valid), 32'd0);
        chk("clear_in_ready", 32'(in_ready), 32'd1);
        chk("clear_gen", 32'(gen_count), 32'd5);
        tick();
        out_ready = 1'b1;
        fr = rand_frame();
        push_model_frame(fr);
        send_frame(fr);
        in_valid = 1'b0;
        drain();
        chk("gen_after_clear", 32'(gen_count), 32'd6);

        // Async reset while stuck in FLUSH
        fr = rand_frame();
        push_model_frame(fr);
        push_row(fr[0]);
        push_row(fr[1]);
        push_row(fr[2]);
        push_row(fr[3]);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_row", 32'(out_row), 32'd0);
        chk("arst_out_last", 32'(out_last), 32'd0);
        chk("arst_gen", 32'(gen_count), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();

        // Recovery frame after reset
        push_exp(8'h08, 1'b0); push_exp(8'h08, 1'b0);
        push_exp(8'h08, 1'b0); push_exp(8'h00, 1'b1);
        out_ready = 1'b1;
        send_frame(blinker);
        in_valid = 1'b0;
        drain();
        chk("gen_after_reset", 32'(gen_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
